// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift-register family (PISO transmitter and
// the right-shifting SIPO receivers).
//   state_t        : transmitter FSM state encoding (IDLE / SHIFT)
//   DEFAULT_WIDTH  : word width used by default on both link ends
//   cntWidth()     : bit-counter width for a given word width (min 1 bit)
// ---------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // A one-bit word still needs a one-bit counter so the port never
  // collapses to zero width; $clog2 alone would give 0 for width 1.
  function automatic int cntWidth(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// ---------------------------------------------------------------------------
// shift_bit_counter
// Counts the bit position of the word currently on the serial line.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset, count returns to 0
//   i_clear    : force the count to 0 on the next edge (highest priority)
//   i_enable   : advance the count by one on the next edge
//   o_count    : current bit position, 0 .. WIDTH-1
//   o_terminal : high while the count sits on the last bit (WIDTH-1)
// ---------------------------------------------------------------------------
module shift_bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cntWidth(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_count,
  output logic          o_terminal
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  // Count register. Clear wins over enable so that a new word loaded on
  // the last bit restarts at position 0. The count also refuses to step
  // past the last position, so it can never wrap even if enable is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/shift_piso_tx.sv
// ---------------------------------------------------------------------------
// shift_piso_tx
// Parallel-in / serial-out transmitter. A word is taken over a valid/ready
// handshake and sent one bit per clock, LSB first by default, so a
// right-shifting SIPO sampling s_out rebuilds the word in place.
//   clk        : system clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset, drops any word in flight
//   p_in       : parallel word, captured only when accepted
//   load_valid : p_in is valid
//   load_ready : a word can be accepted at the next rising edge
//   s_out      : serial data bit
//   s_valid    : s_out carries a data bit this cycle
//   s_first    : current bit is the first of its word
//   s_last     : current bit is the last of its word
//   busy       : transmitter is in the SHIFT state
// ---------------------------------------------------------------------------
module shift_piso_tx
  import shift_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_first,
  output logic             s_last,
  output logic             busy
);

  localparam int CW = cntWidth(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shiftReg;
  logic [CW-1:0]    w_count;
  logic             w_terminal;
  logic             w_accept;
  logic             w_countClear;
  logic             w_countEnable;
  logic             w_outBit;

  // Bit position tracker; its terminal flag marks the last bit of a word,
  // which is also the only SHIFT cycle in which a new word may be taken.
  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bitCounter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_countClear),
    .i_enable   (w_countEnable),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  assign w_outBit = LSB_FIRST ? r_shiftReg[0] : r_shiftReg[WIDTH-1];
  assign w_accept = load_valid & load_ready;

  // State register. Reset lands in IDLE straight away, which forces every
  // serial output low without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. Outputs are functions of registered
  // state only, so s_out only moves on rising edges. On the last bit of a
  // word the block advertises ready; taking a word there keeps us in SHIFT
  // with no idle cycle between words, otherwise we fall back to IDLE.
  always_comb begin
    w_nextState   = r_state;
    load_ready    = 1'b0;
    s_out         = 1'b0;
    s_valid       = 1'b0;
    s_first       = 1'b0;
    s_last        = 1'b0;
    busy          = 1'b0;
    w_countClear  = 1'b1;
    w_countEnable = 1'b0;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        busy          = 1'b1;
        s_valid       = 1'b1;
        s_out         = w_outBit;
        s_first       = (w_count == '0);
        s_last        = w_terminal;
        load_ready    = w_terminal;
        w_countClear  = w_terminal;
        w_countEnable = ~w_terminal;
        if (w_terminal && !load_valid) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Data shift register. An accepted word always overwrites the contents;
  // otherwise, mid-word, the next bit is moved to the output end and the
  // vacated end fills with zero. Nothing shifts on the last bit, so a word
  // that is not followed by another simply stays parked until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shiftReg <= '0;
    end else if (w_accept) begin
      r_shiftReg <= p_in;
    end else if ((r_state == SHIFT) && !w_terminal) begin
      r_shiftReg <= LSB_FIRST ? (r_shiftReg >> 1) : (r_shiftReg << 1);
    end
  end

endmodule

// File: tb/tb_shift_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_shift_piso_tx
// Three transmitter lanes run side by side against one clock and reset:
//   lane 0 : WIDTH=4, LSB first
//   lane 1 : WIDTH=4, MSB first
//   lane 2 : WIDTH=1
// Each lane has a queue model of the expected serial stream; a single
// compare process checks every lane on every falling edge. Directed
// sequences with literal expectations pin the model, then random traffic
// exercises all lanes.
// ---------------------------------------------------------------------------
module tb_shift_piso_tx;

  typedef struct packed {
    logic d;
    logic f;
    logic l;
  } bitEnt_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] pIn       [3];
  logic       loadValid [3];
  logic       loadReady [3];
  logic       sOut      [3];
  logic       sValid    [3];
  logic       sFirst    [3];
  logic       sLast     [3];
  logic       busy      [3];

  logic       expReady  [3];
  logic       expData   [3];
  logic       expValid  [3];
  logic       expFirst  [3];
  logic       expLast   [3];
  logic       expBusy   [3];

  int         errors  = 0;
  int         checks  = 0;
  bit         checkEn = 1'b0;
  logic [3:0] sipoQ   = 4'h0;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and report it if the DUT disagrees.
  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h",
               name, $time, actual, expected);
    end
  endtask

  // Per-lane DUT plus stream model. The model holds every bit still to be
  // seen on the line, front entry being the bit on the line now. A word is
  // accepted whenever at most the current bit remains, and then appends
  // its WIDTH bits in transmission order.
  for (genvar g = 0; g < 3; g++) begin : gLane
    localparam int W = (g == 2) ? 1 : 4;
    localparam bit L = (g == 1) ? 1'b0 : 1'b1;

    bitEnt_t q[$];
    logic eData  = 1'b0;
    logic eFirst = 1'b0;
    logic eLast  = 1'b0;
    logic eValid = 1'b0;
    logic eReady = 1'b1;
    logic eBusy  = 1'b0;

    shift_piso_tx #(
      .WIDTH     (W),
      .LSB_FIRST (L)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p_in       (pIn[g][W-1:0]),
      .load_valid (loadValid[g]),
      .load_ready (loadReady[g]),
      .s_out      (sOut[g]),
      .s_valid    (sValid[g]),
      .s_first    (sFirst[g]),
      .s_last     (sLast[g]),
      .busy       (busy[g])
    );

    always @(posedge clk or negedge rst_n) begin
      bit         acc;
      logic [3:0] word;
      bitEnt_t    ent;
      if (!rst_n) begin
        q.delete();
      end else begin
        acc  = loadValid[g] && (q.size() <= 1);
        word = pIn[g];
        if (q.size() > 0) void'(q.pop_front());
        if (acc) begin
          for (int i = 0; i < W; i++) begin
            ent.d = L ? word[i] : word[W-1-i];
            ent.f = (i == 0);
            ent.l = (i == W - 1);
            q.push_back(ent);
          end
        end
      end
      if (q.size() > 0) begin
        eData  = q[0].d;
        eFirst = q[0].f;
        eLast  = q[0].l;
      end else begin
        eData  = 1'b0;
        eFirst = 1'b0;
        eLast  = 1'b0;
      end
      eValid = (q.size() > 0);
      eBusy  = (q.size() > 0);
      eReady = (q.size() <= 1);
    end

    assign expData[g]  = eData;
    assign expFirst[g] = eFirst;
    assign expLast[g]  = eLast;
    assign expValid[g] = eValid;
    assign expBusy[g]  = eBusy;
    assign expReady[g] = eReady;
  end

  // Receiver-side reference: a right-shifting SIPO sampling on falling
  // edges while lane 0 flags a valid bit.
  always @(negedge clk) begin
    if (sValid[0]) sipoQ <= {sOut[0], sipoQ[3:1]};
  end

  // The single compare process: all lanes, all outputs, every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int g = 0; g < 3; g++) begin
        checkOutput($sformatf("lane%0d s_out", g),   8'(sOut[g]),      8'(expData[g]));
        checkOutput($sformatf("lane%0d s_valid", g), 8'(sValid[g]),    8'(expValid[g]));
        checkOutput($sformatf("lane%0d s_first", g), 8'(sFirst[g]),    8'(expFirst[g]));
        checkOutput($sformatf("lane%0d s_last", g),  8'(sLast[g]),     8'(expLast[g]));
        checkOutput($sformatf("lane%0d busy", g),    8'(busy[g]),      8'(expBusy[g]));
        checkOutput($sformatf("lane%0d ready", g),   8'(loadReady[g]), 8'(expReady[g]));
      end
    end
  end

  // Offer a word on a lane and hold it until accepted (bounded), then
  // drop valid just after the accepting edge.
  task automatic applyStimulus(input int g, input logic [3:0] w);
    int n;
    n = 0;
    pIn[g]       = w;
    loadValid[g] = 1'b1;
    while (!loadReady[g] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("accept wait", 8'(loadReady[g]), 8'h01);
    @(posedge clk);
    #1;
    loadValid[g] = 1'b0;
  endtask

  // Record n cycles of a lane's outputs (bit i = cycle i). If dropAt
  // matches a cycle, valid is released right after the following edge.
  task automatic collect(input int g, input int n, input int dropAt,
                         output logic [7:0] bits, output logic [7:0] firsts,
                         output logic [7:0] lasts, output logic [7:0] valids,
                         output logic [7:0] readys);
    bits = '0; firsts = '0; lasts = '0; valids = '0; readys = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits[i]   = sOut[g];
      firsts[i] = sFirst[g];
      lasts[i]  = sLast[g];
      valids[i] = sValid[g];
      readys[i] = loadReady[g];
      if (i == dropAt) begin
        @(posedge clk);
        #1;
        loadValid[g] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] b, f, l, v, r;
    logic [2:0] seq;

    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      loadValid[g] = 1'b0;
      pIn[g]       = 4'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    checkEn = 1'b1;

    // Reset state
    checkOutput("reset busy",    8'(busy[0]),      8'h00);
    checkOutput("reset s_valid", 8'(sValid[0]),    8'h00);
    checkOutput("reset ready",   8'(loadReady[0]), 8'h01);

    // Single word 1011, LSB first, plus SIPO loopback
    applyStimulus(0, 4'b1011);
    collect(0, 5, -1, b, f, l, v, r);
    checkOutput("single bits",   b, 8'h0B);
    checkOutput("single first",  f, 8'h01);
    checkOutput("single last",   l, 8'h08);
    checkOutput("single valid",  v, 8'h0F);
    checkOutput("single ready",  r, 8'h18);
    #1;
    checkOutput("loopback sipo", 8'(sipoQ), 8'h0B);

    // Back-to-back A then 5
    applyStimulus(0, 4'hA);
    pIn[0]       = 4'h5;
    loadValid[0] = 1'b1;
    collect(0, 8, 3, b, f, l, v, r);
    checkOutput("b2b bits",  b, 8'h5A);
    checkOutput("b2b valid", v, 8'hFF);
    checkOutput("b2b ready", r, 8'h88);
    checkOutput("b2b first", f, 8'h11);
    checkOutput("b2b last",  l, 8'h88);

    // Busy rejection: F offered throughout word 3
    applyStimulus(0, 4'h3);
    pIn[0]       = 4'hF;
    loadValid[0] = 1'b1;
    collect(0, 8, 3, b, f, l, v, r);
    checkOutput("busy bits",  b, 8'hF3);
    checkOutput("busy valid", v, 8'hFF);
    checkOutput("busy ready", r, 8'h88);

    // Reset mid-word: outputs must clear before any clock edge
    applyStimulus(0, 4'b0110);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset outs",
                {3'b000, sOut[0], sValid[0], sFirst[0], sLast[0], busy[0]}, 8'h00);
    checkOutput("async reset ready", 8'(loadReady[0]), 8'h01);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    collect(0, 3, -1, b, f, l, v, r);
    checkOutput("post reset valid", v, 8'h00);
    checkOutput("post reset ready", r, 8'h07);

    // MSB first, 1011 -> 1,0,1,1
    applyStimulus(1, 4'b1011);
    collect(1, 4, -1, b, f, l, v, r);
    checkOutput("msb bits", b, 8'h0D);

    // WIDTH=1 streaming 1,0,1 with no gaps
    seq = 3'b101;
    b = '0; f = '0; l = '0; v = '0; r = '0;
    for (int i = 0; i < 3; i++) begin
      pIn[2]       = {3'b000, seq[i]};
      loadValid[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b[i] = sOut[2];
      f[i] = sFirst[2];
      l[i] = sLast[2];
      v[i] = sValid[2];
      r[i] = loadReady[2];
    end
    #1;
    loadValid[2] = 1'b0;
    checkOutput("w1 bits",  b, 8'h05);
    checkOutput("w1 first", f, 8'h07);
    checkOutput("w1 last",  l, 8'h07);
    checkOutput("w1 valid", v, 8'h07);
    checkOutput("w1 ready", r, 8'h07);

    // Random traffic on all lanes, with one reset pulse in the middle
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        loadValid[g] = ($urandom_range(0, 3) != 0);
        pIn[g]       = 4'($urandom);
      end
      if (cyc == 300) rst_n = 1'b0;
      if (cyc == 302) rst_n = 1'b1;
    end
    for (int g = 0; g < 3; g++) loadValid[g] = 1'b0;
    repeat (6) @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
